// File: rtl/simon_pkg.sv
// ----------------------------------------------------------------------------
// simon_pkg
// Shared definitions for the Simon button front-end.
//   BTN_NUM      : number of physical buttons
//   BTN_IDX_W    : width of an encoded button index
//   DB_CNT_W     : width of each per-button debounce counter
//   state_e      : press-acceptance FSM states (S_IDLE=0, S_HELD=1)
//   onehot_to_idx: encodes a one-hot button vector into its index
// ----------------------------------------------------------------------------
package simon_pkg;

  localparam int unsigned BTN_NUM   = 4;
  localparam int unsigned BTN_IDX_W = 2;
  localparam int unsigned DB_CNT_W  = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_e;

  // Only meaningful for a one-hot input; callers check $onehot first.
  function automatic logic [BTN_IDX_W-1:0] onehot_to_idx(input logic [BTN_NUM-1:0] oh);
    logic [BTN_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < BTN_NUM; i++) begin
      if (oh[i]) idx = BTN_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/simon_btn_input_if.sv
// ----------------------------------------------------------------------------
// simon_btn_input_if
// Press-event channel between the button front-end and the Simon game FSM.
//   btn_valid : one-cycle pulse per accepted press
//   btn_val   : index of the accepted button (valid while btn_valid=1)
//   btn_multi : one-cycle pulse when a multi-button press is rejected
// Modports:
//   master : producer side (simon_btn_input)
//   slave  : consumer side (game FSM / testbench)
// ----------------------------------------------------------------------------
interface simon_btn_input_if;
  import simon_pkg::*;

  logic                 btn_valid;
  logic [BTN_IDX_W-1:0] btn_val;
  logic                 btn_multi;

  modport master (output btn_valid, output btn_val, output btn_multi);
  modport slave  (input  btn_valid, input  btn_val, input  btn_multi);

endinterface

// File: rtl/simon_debounce.sv
// ----------------------------------------------------------------------------
// simon_debounce
// Single-bit two-flop synchroniser followed by a debounce counter. The
// debounced level only changes after the synchronised level has differed
// from it for DEBOUNCE_CYCLES consecutive samples; this applies equally to
// press and release.
// Parameters:
//   DEBOUNCE_CYCLES : samples required before db_o changes (2..15)
// Ports:
//   clk_tick : game tick clock, rising edge
//   reset_n  : asynchronous active-low reset
//   btn_i    : raw button level, active-high, asynchronous to clk_tick
//   db_o     : debounced button level
// ----------------------------------------------------------------------------
module simon_debounce
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_tick,
  input  logic reset_n,
  input  logic btn_i,
  output logic db_o
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]          sync_q;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                db_q, db_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours (the synchroniser chain
  // depends on this to stay two stages deep).
  always_ff @(posedge clk_tick or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  // NOTE: every signal written here is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = ~db_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DB_CNT_W'(1);
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/simon_btn_input.sv
// ----------------------------------------------------------------------------
// simon_btn_input
// Button front-end for the Simon game. Each raw button is synchronised and
// debounced, then a two-state FSM accepts exactly one clean press per
// physical actuation and reports it as a single-cycle pulse with an encoded
// index. Presses with more than one button down are rejected with a
// btn_multi pulse instead.
// Parameters:
//   DEBOUNCE_CYCLES : debounce length in samples (2..15), default 4
// Ports:
//   clk_tick  : game tick clock, rising edge
//   reset_n   : asynchronous active-low reset
//   btn_raw   : raw button lines, bit i = button i
//   btn_if    : press-event channel (btn_valid / btn_val / btn_multi)
//   btn_db    : debounced button levels (debug)
//   press_cnt : accepted-press count, wraps 255->0 (debug)
// Build option:
//   SIMON_BTN_ACTIVE_LOW_EN : when defined, btn_raw is active-low
//                             (pull-up buttons, 0 = pressed).
// ----------------------------------------------------------------------------
module simon_btn_input
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk_tick,
  input  logic                 reset_n,
  input  logic [BTN_NUM-1:0]   btn_raw,
  simon_btn_input_if.master    btn_if,
  output logic [BTN_NUM-1:0]   btn_db,
  output logic [7:0]           press_cnt
);

  // Normalise to "1 = pressed" ahead of the synchronisers. With active-low
  // buttons the synchroniser's reset value of 0 here corresponds to a raw
  // level of 1 (released), so nothing looks pressed out of reset.
  logic [BTN_NUM-1:0] raw_pressed;

`ifdef SIMON_BTN_ACTIVE_LOW_EN
  assign raw_pressed = ~btn_raw;
`else
  assign raw_pressed = btn_raw;
`endif

  for (genvar i = 0; i < BTN_NUM; i++) begin : g_db
    simon_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_tick (clk_tick),
      .reset_n  (reset_n),
      .btn_i    (raw_pressed[i]),
      .db_o     (btn_db[i])
    );
  end

  state_e               state_q, state_d;
  logic                 valid_q, valid_d;
  logic                 multi_q, multi_d;
  logic [BTN_IDX_W-1:0] val_q, val_d;
  logic [7:0]           cnt_q, cnt_d;

  always_ff @(posedge clk_tick or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      val_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pulses default low each cycle, so a single decision in S_IDLE yields a
  // one-cycle output; btn_val keeps its last value between presses.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    multi_d = 1'b0;
    val_d   = val_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (btn_db != '0) begin
          state_d = S_HELD;
          if ($onehot(btn_db)) begin
            valid_d = 1'b1;
            val_d   = onehot_to_idx(btn_db);
            cnt_d   = cnt_q + 8'd1;
          end else begin
            // Buttons that debounce on the same edge land here too.
            multi_d = 1'b1;
          end
        end
      end
      S_HELD: begin
        // Extra buttons pressed while one is held are ignored; only a full
        // release re-arms acceptance.
        if (btn_db == '0) state_d = S_IDLE;
      end
    endcase
  end

  assign btn_if.btn_valid = valid_q;
  assign btn_if.btn_multi = multi_q;
  assign btn_if.btn_val   = val_q;
  assign press_cnt        = cnt_q;

endmodule

// File: tb/tb_simon_btn_input.sv
// ----------------------------------------------------------------------------
// tb_simon_btn_input
// Self-checking bench for simon_btn_input (default DEBOUNCE_CYCLES = 4).
// Expected presses are queued as stimulus is driven; a negedge monitor pops
// and compares them whenever the DUT pulses btn_valid / btn_multi.
// ----------------------------------------------------------------------------
module tb_simon_btn_input;

  logic       clk_tick;
  logic       reset_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_db;
  logic [7:0] press_cnt;

  simon_btn_input_if bif ();

  simon_btn_input #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk_tick  (clk_tick),
    .reset_n   (reset_n),
    .btn_raw   (btn_raw),
    .btn_if    (bif),
    .btn_db    (btn_db),
    .press_cnt (press_cnt)
  );

  initial clk_tick = 1'b0;
  always #5 clk_tick = ~clk_tick;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected accepted presses and rejected multi-presses.
  typedef struct packed {
    logic [1:0] val;
    logic [7:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         exp_multi = 0;
  logic [7:0] exp_cnt   = 8'd0;

  task automatic expect_press(input logic [1:0] idx);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.val   = idx;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk_tick) begin
    if (reset_n === 1'b1) begin
      if (bif.btn_valid || bif.btn_multi)
        check("valid_multi_exclusive", {31'd0, bif.btn_valid & bif.btn_multi}, 32'd0);
      if (bif.btn_valid) begin
        check("valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("valid_btn_val", {30'd0, bif.btn_val}, {30'd0, e.val});
          check("valid_press_cnt", {24'd0, press_cnt}, {24'd0, e.cnt});
        end
      end
      if (bif.btn_multi) begin
        check("multi_expected", {31'd0, exp_multi != 0}, 32'd1);
        if (exp_multi != 0) exp_multi--;
      end
    end
  end

  // All stimulus is written in "1 = pressed" terms.
  task automatic set_raw(input logic [3:0] pressed);
`ifdef SIMON_BTN_ACTIVE_LOW_EN
    btn_raw = ~pressed;
`else
    btn_raw = pressed;
`endif
  endtask

  task automatic drain(input string name);
    check({name, "_valid_drain"}, exp_q.size(), 32'd0);
    check({name, "_multi_drain"}, exp_multi, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_tick);
    reset_n = 1'b0;
    set_raw(4'b0000);
    exp_q.delete();
    exp_multi = 0;
    exp_cnt   = 8'd0;
    repeat (2) @(negedge clk_tick);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] raw;
    int         hold;
    logic       exp_valid;
    logic [1:0] exp_val;
    logic       exp_multi;
    logic [3:0] exp_db;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // hold = number of rising edges that sample the pressed level;
    // exp_db = debounced level three edges after the press ends.
    vecs[0] = '{4'b0001, 10, 1'b1, 2'd0, 1'b0, 4'b0001};
    vecs[1] = '{4'b0010,  3, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[2] = '{4'b0010,  4, 1'b1, 2'd1, 1'b0, 4'b0010};
    vecs[3] = '{4'b0100,  8, 1'b1, 2'd2, 1'b0, 4'b0100};
    vecs[4] = '{4'b0011,  8, 1'b0, 2'd0, 1'b1, 4'b0011};
    vecs[5] = '{4'b0001,  8, 1'b1, 2'd0, 1'b0, 4'b0001};
    vecs[6] = '{4'b1111,  8, 1'b0, 2'd0, 1'b1, 4'b1111};
    vecs[7] = '{4'b0110,  3, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[8] = '{4'b1000, 20, 1'b1, 2'd3, 1'b0, 4'b1000};

    // ---- Reset with button 2 already held -------------------------------
    reset_n = 1'b0;
    set_raw(4'b0100);
    repeat (3) @(negedge clk_tick);
    check("rst_btn_valid", {31'd0, bif.btn_valid}, 32'd0);
    check("rst_btn_val",   {30'd0, bif.btn_val},   32'd0);
    check("rst_btn_multi", {31'd0, bif.btn_multi}, 32'd0);
    check("rst_btn_db",    {28'd0, btn_db},        32'd0);
    check("rst_press_cnt", {24'd0, press_cnt},     32'd0);
    reset_n = 1'b1;
    expect_press(2'd2);
    repeat (5) @(negedge clk_tick);
    check("rst_db_edge5", {28'd0, btn_db}, 32'd0);
    @(negedge clk_tick);
    check("rst_db_edge6", {28'd0, btn_db}, 32'h4);
    check("rst_valid_edge6", {31'd0, bif.btn_valid}, 32'd0);
    @(negedge clk_tick);
    check("rst_valid_edge7", {31'd0, bif.btn_valid}, 32'd1);
    check("rst_val_edge7", {30'd0, bif.btn_val}, 32'd2);
    check("rst_cnt_edge7", {24'd0, press_cnt}, 32'd1);
    set_raw(4'b0000);
    repeat (20) @(negedge clk_tick);
    drain("rst");

    // ---- Table-driven presses -------------------------------------------
    foreach (vecs[i]) begin
      @(negedge clk_tick);
      set_raw(vecs[i].raw);
      if (vecs[i].exp_valid) expect_press(vecs[i].exp_val);
      if (vecs[i].exp_multi) exp_multi++;
      repeat (vecs[i].hold) @(negedge clk_tick);
      set_raw(4'b0000);
      repeat (3) @(negedge clk_tick);
      check($sformatf("vec%0d_db", i), {28'd0, btn_db}, {28'd0, vecs[i].exp_db});
      repeat (20) @(negedge clk_tick);
      drain($sformatf("vec%0d", i));
    end

    // ---- Bounce on button 3, then steady --------------------------------
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_tick);
      set_raw((k % 2 == 0) ? 4'b1000 : 4'b0000);
    end
    @(negedge clk_tick);
    set_raw(4'b1000);
    expect_press(2'd3);
    repeat (6) @(negedge clk_tick);
    check("bounce_db_s5", {28'd0, btn_db}, 32'h8);
    check("bounce_valid_s5", {31'd0, bif.btn_valid}, 32'd0);
    @(negedge clk_tick);
    check("bounce_valid_s6", {31'd0, bif.btn_valid}, 32'd1);
    repeat (4) @(negedge clk_tick);
    set_raw(4'b0000);
    repeat (20) @(negedge clk_tick);
    drain("bounce");

    // ---- Hold button 0, add button 2 while held -------------------------
    do_reset();
    @(negedge clk_tick);
    set_raw(4'b0001);
    expect_press(2'd0);
    repeat (10) @(negedge clk_tick);
    set_raw(4'b0101);
    repeat (15) @(negedge clk_tick);
    check("held_db_both", {28'd0, btn_db}, 32'h5);
    set_raw(4'b0000);
    repeat (20) @(negedge clk_tick);
    drain("held_first");
    set_raw(4'b0100);
    expect_press(2'd2);
    repeat (10) @(negedge clk_tick);
    set_raw(4'b0000);
    repeat (20) @(negedge clk_tick);
    check("held_press_cnt", {24'd0, press_cnt}, 32'd2);
    drain("held_second");

    // ---- 256 accepted presses wrap the counter --------------------------
    do_reset();
    for (int k = 0; k < 256; k++) begin
      @(negedge clk_tick);
      set_raw(4'b0001 << (k % 4));
      expect_press(2'(k % 4));
      repeat (6) @(negedge clk_tick);
      set_raw(4'b0000);
      repeat (10) @(negedge clk_tick);
    end
    check("wrap_press_cnt", {24'd0, press_cnt}, 32'd0);
    drain("wrap");

    // ---- Asynchronous reset during a valid pulse ------------------------
    do_reset();
    @(negedge clk_tick);
    set_raw(4'b0001);
    expect_press(2'd0);
    repeat (7) @(negedge clk_tick);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_btn_valid", {31'd0, bif.btn_valid}, 32'd0);
    check("arst_btn_val",   {30'd0, bif.btn_val},   32'd0);
    check("arst_btn_db",    {28'd0, btn_db},        32'd0);
    check("arst_press_cnt", {24'd0, press_cnt},     32'd0);
    exp_q.delete();
    exp_cnt = 8'd0;
    repeat (2) @(negedge clk_tick);
    reset_n = 1'b1;
    // Button still held: counts as a fresh press once debounced again.
    expect_press(2'd0);
    repeat (12) @(negedge clk_tick);
    set_raw(4'b0000);
    repeat (20) @(negedge clk_tick);
    check("arst_repress_cnt", {24'd0, press_cnt}, 32'd1);
    drain("arst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
